tron_controller: RTL and testbench

//  Multi-cycle control FSM for the 16-bit Tron datapath.
//  - Fetches the instruction word from memData into an internal IR, decodes it, and sequences
//    the datapath: register file, ALU, shifter, bus mux and program counter.
//  - Drives every datapath control input and provides a memory address select.
//  - Memory is variable-latency: completion is signalled on mem_ready.

---
 rtl/tron_ctrl_pkg.sv | 89 ++++++++
 rtl/tron_controller_if.sv | 39 +++
 rtl/tron_decoder.sv | 102 ++++++++++
 rtl/tron_controller.sv | 118 +++++++++++
 tb/tb_tron_controller.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_ctrl_pkg.sv
// Shared definitions for the Tron control path: FSM states, instruction
// encodings and the ALU/bus function codes also used by the datapath blocks.
package tron_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_LDWB,
    S_TRAP
  } state_t;

  // Primary opcodes, IR[15:12]. Immediate ALU opcodes reuse the R-type
  // opext value of the matching register operation.
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // Extended opcodes, IR[7:4]
  localparam logic [3:0] EXT_AND   = 4'h1;
  localparam logic [3:0] EXT_OR    = 4'h2;
  localparam logic [3:0] EXT_XOR   = 4'h3;
  localparam logic [3:0] EXT_ADD   = 4'h5;
  localparam logic [3:0] EXT_SUB   = 4'h9;
  localparam logic [3:0] EXT_CMP   = 4'hB;
  localparam logic [3:0] EXT_MOV   = 4'hD;
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JCOND = 4'hC;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_MOV = 4'd5;

  // Bus mux selects
  localparam logic [2:0] BUS_IMM   = 3'd0;
  localparam logic [2:0] BUS_MEM   = 3'd1;
  localparam logic [2:0] BUS_ALU   = 3'd2;
  localparam logic [2:0] BUS_SHIFT = 3'd3;
  localparam logic [2:0] BUS_PC    = 3'd4;

  // Instruction classes: what the FSM has to do with a decoded word
  typedef enum logic [2:0] {
    CLS_ILLEGAL,
    CLS_WRITE,
    CLS_CMP,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LOAD,
    CLS_STOR
  } cls_t;

  typedef struct packed {
    cls_t       cls;
    logic [3:0] aluOp;
    logic [1:0] shiftOp;
    logic [2:0] busOp;
    logic       immMUX;
  } ctrl_t;

  // Map an ALU function field to {valid, ALU code}; CMP computes a subtract.
  function automatic logic [4:0] aluFromFunc(input logic [3:0] func);
    case (func)
      EXT_AND: return {1'b1, ALU_AND};
      EXT_OR:  return {1'b1, ALU_OR};
      EXT_XOR: return {1'b1, ALU_XOR};
      EXT_ADD: return {1'b1, ALU_ADD};
      EXT_SUB: return {1'b1, ALU_SUB};
      EXT_CMP: return {1'b1, ALU_SUB};
      EXT_MOV: return {1'b1, ALU_MOV};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/tron_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface tron_controller_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [15:0]        memData;
  logic               mem_ready;
  logic [7:0]         instructionOp;
  logic [WIDTH-1:0]   immediate;
  logic [REGBITS-1:0] regAddA;
  logic [REGBITS-1:0] regAddB;
  logic [3:0]         ALUOp;
  logic [1:0]         shiftOp;
  logic [2:0]         busOp;
  logic               immMUX;
  logic               regWrite;
  logic               memWrite;
  logic               memAddrSel;
  logic [3:0]         flagOp;
  logic               flagWrite;
  logic               pcAdd;
  logic               pcJump;
  logic               pcBranch;
  logic               illegal;

  modport master (
    input  memData, mem_ready,
    output instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp, busOp,
           immMUX, regWrite, memWrite, memAddrSel, flagOp, flagWrite,
           pcAdd, pcJump, pcBranch, illegal
  );

  modport slave (
    output memData, mem_ready,
    input  instructionOp, immediate, regAddA, regAddB, ALUOp, shiftOp, busOp,
           immMUX, regWrite, memWrite, memAddrSel, flagOp, flagWrite,
           pcAdd, pcJump, pcBranch, illegal
  );
endinterface

// File: rtl/tron_decoder.sv
// Combinational instruction decode: IR -> datapath control word + immediate.
module tron_decoder
  import tron_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      ir,
  output ctrl_t            ctrl,
  output logic [WIDTH-1:0] immediate
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [4:0] aluR;
  logic [4:0] aluI;

  assign op   = ir[15:12];
  assign ext  = ir[7:4];
  assign aluR = aluFromFunc(ext);
  assign aluI = aluFromFunc(op);

  // Decode opcode/opext into class, unit function codes and immediate form
  always_comb begin
    ctrl      = '{cls: CLS_ILLEGAL, aluOp: ALU_ADD, shiftOp: 2'b00,
                  busOp: BUS_IMM, immMUX: 1'b0};
    immediate = '0;
    case (op)
      OP_RTYPE: begin
        if (aluR[4]) begin
          ctrl.cls   = (ext == EXT_CMP) ? CLS_CMP : CLS_WRITE;
          ctrl.aluOp = aluR[3:0];
          ctrl.busOp = BUS_ALU;
        end
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        // Logical immediates are zero-extended
        ctrl.cls    = CLS_WRITE;
        ctrl.aluOp  = aluI[3:0];
        ctrl.busOp  = BUS_ALU;
        ctrl.immMUX = 1'b1;
        immediate   = WIDTH'(ir[7:0]);
      end
      OP_ADDI, OP_SUBI, OP_CMPI: begin
        ctrl.cls    = (op == OP_CMPI) ? CLS_CMP : CLS_WRITE;
        ctrl.aluOp  = aluI[3:0];
        ctrl.busOp  = BUS_ALU;
        ctrl.immMUX = 1'b1;
        immediate   = WIDTH'($signed(ir[7:0]));
      end
      OP_MOVI: begin
        // The immediate goes straight onto the bus
        ctrl.cls    = CLS_WRITE;
        ctrl.aluOp  = ALU_MOV;
        ctrl.busOp  = BUS_IMM;
        ctrl.immMUX = 1'b1;
        immediate   = WIDTH'($signed(ir[7:0]));
      end
      OP_LUI: begin
        ctrl.cls    = CLS_WRITE;
        ctrl.aluOp  = ALU_MOV;
        ctrl.busOp  = BUS_IMM;
        ctrl.immMUX = 1'b1;
        immediate   = WIDTH'({ir[7:0], 8'h00});
      end
      OP_MEM: begin
        case (ext)
          EXT_LOAD: begin
            ctrl.cls   = CLS_LOAD;
            ctrl.busOp = BUS_MEM;
          end
          EXT_STOR: begin
            ctrl.cls   = CLS_STOR;
            ctrl.busOp = BUS_ALU;
          end
          EXT_JCOND: begin
            ctrl.cls   = CLS_JUMP;
            ctrl.busOp = BUS_PC;
          end
          default: ;
        endcase
      end
      OP_SHIFT: begin
        // opext[1:0] is the shifter function, opext[2] selects an
        // immediate amount taken from IR[3:0]; opext[3] is reserved
        if (!ext[3]) begin
          ctrl.cls     = CLS_WRITE;
          ctrl.shiftOp = ext[1:0];
          ctrl.busOp   = BUS_SHIFT;
          ctrl.immMUX  = ext[2];
          immediate    = ext[2] ? WIDTH'(ir[3:0]) : '0;
        end
      end
      OP_BCOND: begin
        ctrl.cls   = CLS_BRANCH;
        ctrl.busOp = BUS_PC;
        immediate  = WIDTH'($signed(ir[7:0]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tron_controller.sv
// Multi-cycle control FSM for the Tron datapath: fetch, decode, execute,
// memory access and load write-back with variable-latency memory.
module tron_controller
  import tron_ctrl_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  tron_controller_if.master bus
);

  state_t           stateReg;
  state_t           stateNext;
  logic [15:0]      irReg;
  logic             illegalReg;
  ctrl_t            ctrl;
  logic [WIDTH-1:0] decImmediate;

  tron_decoder #(.WIDTH(WIDTH)) decoder (
    .ir        (irReg),
    .ctrl      (ctrl),
    .immediate (decImmediate)
  );

  // Fields and function codes come straight from the IR; only strobes are gated
  assign bus.instructionOp = {irReg[15:12], irReg[7:4]};
  assign bus.regAddA       = REGBITS'(irReg[3:0]);
  assign bus.regAddB       = REGBITS'(irReg[11:8]);
  assign bus.flagOp        = irReg[11:8];
  assign bus.immediate     = decImmediate;
  assign bus.ALUOp         = ctrl.aluOp;
  assign bus.shiftOp       = ctrl.shiftOp;
  assign bus.immMUX        = ctrl.immMUX;
  assign bus.illegal       = illegalReg;

  // State register, IR capture on fetch completion, sticky illegal flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg   <= S_FETCH;
      irReg      <= '0;
      illegalReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      if (stateReg == S_FETCH && bus.mem_ready) begin
        irReg <= bus.memData;
      end
      if (stateReg == S_DECODE && ctrl.cls == CLS_ILLEGAL) begin
        illegalReg <= 1'b1;
      end
    end
  end

  // Next-state logic and state-gated strobes
  always_comb begin
    stateNext      = stateReg;
    bus.regWrite   = 1'b0;
    bus.memWrite   = 1'b0;
    bus.flagWrite  = 1'b0;
    bus.pcAdd      = 1'b0;
    bus.pcJump     = 1'b0;
    bus.pcBranch   = 1'b0;
    bus.memAddrSel = 1'b0;
    bus.busOp      = BUS_IMM;
    case (stateReg)
      S_FETCH: begin
        if (bus.mem_ready) stateNext = S_DECODE;
      end
      S_DECODE: begin
        bus.busOp = ctrl.busOp;
        stateNext = (ctrl.cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        bus.busOp = ctrl.busOp;
        stateNext = S_FETCH;
        case (ctrl.cls)
          CLS_WRITE: begin
            bus.regWrite = 1'b1;
            bus.pcAdd    = 1'b1;
          end
          CLS_CMP: begin
            bus.flagWrite = 1'b1;
            bus.pcAdd     = 1'b1;
          end
          CLS_BRANCH: bus.pcBranch = 1'b1;
          CLS_JUMP:   bus.pcJump   = 1'b1;
          CLS_LOAD, CLS_STOR: stateNext = S_MEM;
          default: stateNext = S_TRAP;
        endcase
      end
      S_MEM: begin
        // Store data is presented for the whole access, so the write strobe
        // stays high until memory accepts it
        bus.memAddrSel = 1'b1;
        bus.busOp      = ctrl.busOp;
        if (ctrl.cls == CLS_STOR) bus.memWrite = 1'b1;
        if (bus.mem_ready) begin
          if (ctrl.cls == CLS_STOR) begin
            bus.pcAdd = 1'b1;
            stateNext = S_FETCH;
          end else begin
            stateNext = S_LDWB;
          end
        end
      end
      S_LDWB: begin
        bus.busOp    = BUS_MEM;
        bus.regWrite = 1'b1;
        bus.pcAdd    = 1'b1;
        stateNext    = S_FETCH;
      end
      S_TRAP: ;
      default: stateNext = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_tron_controller.sv
// Self-checking bench for tron_controller: directed scenarios plus random
// instructions with random memory wait states, checked against a
// cycle-count/strobe-count model of the instruction set.
module tb_tron_controller;

  logic clk = 1'b0;
  logic reset;
  int   nTests = 0;
  int   nFails = 0;

  always #5 clk = ~clk;

  tron_controller_if #(.WIDTH(16), .REGBITS(4)) bus ();

  tron_controller #(.WIDTH(16), .REGBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Expected behaviour of one instruction
  typedef struct packed {
    logic [15:0] imm;
    logic [2:0]  busSel;
    logic        immSel;
    logic        regW;
    logic        flagW;
    logic        isMem;
    logic        isLoad;
    logic        isJump;
    logic        isBranch;
    logic        legal;
  } ref_t;

  logic [3:0] rtypeExt [7] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD};
  logic [3:0] immOps   [8] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB, 4'hD, 4'hF};
  logic [3:0] memExt   [3] = '{4'h0, 4'h4, 4'hC};
  logic [3:0] badOps   [4] = '{4'h6, 4'h7, 4'hA, 4'hE};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction-set model: what each mnemonic must do
  function automatic ref_t refDecode(input logic [15:0] ir);
    ref_t r;
    int op, ext, lo8, sx8;
    op  = int'(ir[15:12]);
    ext = int'(ir[7:4]);
    lo8 = int'(ir[7:0]);
    sx8 = (lo8 >= 128) ? lo8 - 256 : lo8;
    r = '0;
    r.legal = 1'b1;
    case (op)
      0: begin
        r.busSel = 3'd2;
        if (!(ext inside {1, 2, 3, 5, 9, 11, 13})) r.legal = 1'b0;
        else if (ext == 11) r.flagW = 1'b1;
        else r.regW = 1'b1;
      end
      1, 2, 3: begin r.regW = 1'b1; r.busSel = 3'd2; r.immSel = 1'b1; r.imm = 16'(lo8); end
      5, 9:    begin r.regW = 1'b1; r.busSel = 3'd2; r.immSel = 1'b1; r.imm = 16'(sx8); end
      11:      begin r.flagW = 1'b1; r.busSel = 3'd2; r.immSel = 1'b1; r.imm = 16'(sx8); end
      13:      begin r.regW = 1'b1; r.busSel = 3'd0; r.immSel = 1'b1; r.imm = 16'(sx8); end
      15:      begin r.regW = 1'b1; r.busSel = 3'd0; r.immSel = 1'b1; r.imm = 16'(lo8 * 256); end
      4: begin
        if (ext == 0) begin r.regW = 1'b1; r.isMem = 1'b1; r.isLoad = 1'b1; r.busSel = 3'd1; end
        else if (ext == 4) r.isMem = 1'b1;
        else if (ext == 12) r.isJump = 1'b1;
        else r.legal = 1'b0;
      end
      8: begin
        if (ext >= 8) r.legal = 1'b0;
        else begin
          r.regW   = 1'b1;
          r.busSel = 3'd3;
          r.immSel = (ext >= 4);
          r.imm    = (ext >= 4) ? 16'(int'(ir[3:0])) : 16'd0;
        end
      end
      12: begin r.isBranch = 1'b1; r.imm = 16'(sx8); end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] genInstr();
    logic [15:0] ir;
    ir = 16'($urandom);
    case ($urandom_range(0, 4))
      0: begin ir[15:12] = 4'h0; ir[7:4] = rtypeExt[$urandom_range(0, 6)]; end
      1: ir[15:12] = immOps[$urandom_range(0, 7)];
      2: begin ir[15:12] = 4'h4; ir[7:4] = memExt[$urandom_range(0, 2)]; end
      3: begin ir[15:12] = 4'h8; ir[7] = 1'b0; end
      default: ir[15:12] = 4'hC;
    endcase
    return ir;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Run one legal instruction from FETCH: fw fetch wait cycles, mw memory wait cycles
  task automatic runInstr(input logic [15:0] ir, input int fw, input int mw);
    ref_t r;
    int execC, memStart, retire;
    int nPcAdd, nPcJump, nPcBranch, pcCycle, nRegW, regWCycle;
    int nMemW, nAddr, nFlagW, nIll, fetchAddr;
    logic [15:0] immX;
    logic [2:0]  busX, busWb;
    logic        immMuxX;
    logic [3:0]  flagOpX, regAX, regBX;
    logic [7:0]  instrOpX;
    r = refDecode(ir);
    execC    = fw + 2;
    memStart = fw + 3;
    retire   = r.isMem ? memStart + mw + (r.isLoad ? 1 : 0) : execC;
    nPcAdd = 0; nPcJump = 0; nPcBranch = 0; pcCycle = -1; nRegW = 0; regWCycle = -1;
    nMemW = 0; nAddr = 0; nFlagW = 0; nIll = 0; fetchAddr = 0;
    immX = '0; busX = '0; busWb = '0; immMuxX = 1'b0; flagOpX = '0; regAX = '0; regBX = '0; instrOpX = '0;
    for (int c = 0; c <= retire; c++) begin
      if (c == fw) begin
        bus.mem_ready = 1'b1;
        bus.memData   = ir;
      end else if (c < fw || (r.isMem && c >= memStart && c < memStart + mw)) begin
        bus.mem_ready = 1'b0;
        bus.memData   = 16'($urandom);
      end else if (r.isMem && c == memStart + mw) begin
        bus.mem_ready = 1'b1;
        bus.memData   = 16'($urandom);
      end else begin
        bus.mem_ready = 1'($urandom);
        bus.memData   = 16'($urandom);
      end
      @(negedge clk);
      if (bus.pcAdd)    nPcAdd++;
      if (bus.pcJump)   nPcJump++;
      if (bus.pcBranch) nPcBranch++;
      if (bus.pcAdd || bus.pcJump || bus.pcBranch) pcCycle = c;
      if (bus.regWrite) begin nRegW++; regWCycle = c; end
      if (bus.memWrite)  nMemW++;
      if (bus.memAddrSel) nAddr++;
      if (bus.memAddrSel && c <= fw) fetchAddr++;
      if (bus.flagWrite) nFlagW++;
      if (bus.illegal)   nIll++;
      if (c == execC) begin
        immX = bus.immediate; busX = bus.busOp; immMuxX = bus.immMUX;
        flagOpX = bus.flagOp; regAX = bus.regAddA; regBX = bus.regAddB;
        instrOpX = bus.instructionOp;
      end
      if (r.isLoad && c == retire) busWb = bus.busOp;
      nextCycle();
    end
    check("retireCycle", 32'(pcCycle), 32'(retire));
    check("pcStrobes", 32'(nPcAdd + nPcJump + nPcBranch), 32'd1);
    check("pcJump", 32'(nPcJump), 32'(r.isJump));
    check("pcBranch", 32'(nPcBranch), 32'(r.isBranch));
    check("regWriteCount", 32'(nRegW), 32'(r.regW));
    if (r.regW) check("regWriteCycle", 32'(regWCycle), 32'(retire));
    check("memWriteCount", 32'(nMemW), (r.isMem && !r.isLoad) ? 32'(mw + 1) : 32'd0);
    check("memAddrSelCount", 32'(nAddr), r.isMem ? 32'(mw + 1) : 32'd0);
    check("fetchAddrSel", 32'(fetchAddr), 32'd0);
    check("flagWrite", 32'(nFlagW), 32'(r.flagW));
    check("illegalQuiet", 32'(nIll), 32'd0);
    check("immediate", 32'(immX), 32'(r.imm));
    check("immMUX", 32'(immMuxX), 32'(r.immSel));
    check("flagOp", 32'(flagOpX), 32'(ir[11:8]));
    check("regAddA", 32'(regAX), 32'(ir[3:0]));
    check("regAddB", 32'(regBX), 32'(ir[11:8]));
    check("instructionOp", 32'(instrOpX), 32'({ir[15:12], ir[7:4]}));
    if (r.regW && !r.isLoad) check("busOpExec", 32'(busX), 32'(r.busSel));
    if (r.isLoad) check("busOpLdwb", 32'(busWb), 32'd1);
    $display("[TB] instr ir=%h fw=%0d mw=%0d cycles=%0d", ir, fw, mw, retire + 1);
  endtask

  // Apply reset for n cycles; DUT is in FETCH on return
  task automatic applyReset(input int n);
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (n) nextCycle();
    @(negedge clk);
    check("rstIllegal", 32'(bus.illegal), 32'd0);
    check("rstAddrSel", 32'(bus.memAddrSel), 32'd0);
    check("rstStrobes", 32'({bus.regWrite, bus.memWrite, bus.flagWrite,
                             bus.pcAdd, bus.pcJump, bus.pcBranch}), 32'd0);
    check("rstBusOp", 32'(bus.busOp), 32'd0);
    nextCycle();
    reset = 1'b1;
  endtask

  // Undefined instruction: trap, stay silent, clear only on reset
  task automatic runIllegal(input logic [15:0] ir, input int fw);
    int nStrobe, nIll;
    nStrobe = 0;
    nIll = 0;
    for (int c = 0; c <= fw + 1; c++) begin
      bus.mem_ready = (c == fw) ? 1'b1 : ((c < fw) ? 1'b0 : 1'($urandom));
      bus.memData   = (c == fw) ? ir : 16'($urandom);
      @(negedge clk);
      nStrobe += int'(bus.regWrite) + int'(bus.memWrite) + int'(bus.flagWrite)
               + int'(bus.pcAdd) + int'(bus.pcJump) + int'(bus.pcBranch);
      nextCycle();
    end
    for (int c = 0; c < 20; c++) begin
      bus.mem_ready = 1'($urandom);
      bus.memData   = 16'($urandom);
      @(negedge clk);
      nStrobe += int'(bus.regWrite) + int'(bus.memWrite) + int'(bus.flagWrite)
               + int'(bus.pcAdd) + int'(bus.pcJump) + int'(bus.pcBranch);
      if (bus.illegal) nIll++;
      nextCycle();
    end
    check("trapStrobes", 32'(nStrobe), 32'd0);
    check("trapIllegal", 32'(nIll), 32'd20);
    $display("[TB] illegal ir=%h fw=%0d trapped", ir, fw);
    applyReset(1);
  endtask

  initial begin
    logic [15:0] ir;
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    bus.memData = 16'h0000;

    // Reset state
    repeat (2) nextCycle();
    @(negedge clk);
    check("resetIllegal", 32'(bus.illegal), 32'd0);
    check("resetStrobes", 32'({bus.regWrite, bus.memWrite, bus.flagWrite,
                               bus.pcAdd, bus.pcJump, bus.pcBranch}), 32'd0);
    check("resetBusOp", 32'(bus.busOp), 32'd0);
    check("resetAddrSel", 32'(bus.memAddrSel), 32'd0);
    check("resetIR", 32'(bus.instructionOp), 32'd0);
    nextCycle();
    reset = 1'b1;

    // ADDI R3,#-2 with zero-wait memory
    runInstr(16'h53FE, 0, 0);
    // LOAD R5,[R2] with three memory wait cycles
    runInstr(16'h4502, 0, 3);
    // STOR accepted on its first memory cycle
    runInstr(16'h4142, 0, 0);
    // Bcond EQ, displacement -4
    runInstr(16'hC0FC, 0, 0);
    // LUI and logical immediate zero-extension
    runInstr(16'hF2A5, 1, 0);
    runInstr(16'h1480, 0, 0);

    // Reset asserted for two cycles while a STOR waits in MEM
    bus.mem_ready = 1'b1; bus.memData = 16'h4142;
    nextCycle();
    bus.mem_ready = 1'b0;
    repeat (2) nextCycle();
    @(negedge clk);
    check("storWaiting", 32'(bus.memWrite), 32'd1);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    check("storRstPcAdd", 32'(bus.pcAdd), 32'd0);
    nextCycle();
    @(negedge clk);
    check("midRstMemWrite", 32'(bus.memWrite), 32'd0);
    check("midRstPc", 32'({bus.pcAdd, bus.pcJump, bus.pcBranch}), 32'd0);
    check("midRstAddrSel", 32'(bus.memAddrSel), 32'd0);
    nextCycle();
    reset = 1'b1;
    runInstr(16'h0259, 0, 0);

    // Undefined opext, then an undefined opcode
    runIllegal(16'h0F00, 0);
    ir = 16'($urandom);
    ir[15:12] = badOps[$urandom_range(0, 3)];
    runIllegal(ir, $urandom_range(0, 2));

    // Random instruction stream with random wait states
    for (int i = 0; i < 40; i++) begin
      runInstr(genInstr(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
